rgb_mem_arb: RTL

- Shares one 16K x 8 colour-plane SRAM port (wr/addr/wdata/rdata, as used by each of the r/g/b planes) between NREQ requesters: raw loader, interpolation engine, host readout.
- One instance per colour plane, placed between the demosaic engines and the plane memory.
- Round-robin arbitration with optional burst lock.
- Returns read data to the owning requester with a fixed latency.

---
 rtl/demosaic_pkg.sv | 11 +
 rtl/rr_pick.sv | 19 +
 rtl/rgb_mem_arb.sv | 112 +++++++++++
 3 files changed

// File: rtl/demosaic_pkg.sv
// demosaic_pkg: shared image/memory geometry, requester indices and arbiter state type.
package demosaic_pkg;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 8;
  localparam int IMG_W      = 128;
  localparam int NREQ       = 3;
  localparam int REQ_LOAD   = 0;
  localparam int REQ_INTERP = 1;
  localparam int REQ_HOST   = 2;
  typedef enum logic {ARB, LOCK} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set req at or above ptr (mod N).
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  import demosaic_pkg::*;
  // scan farthest-first so the nearest set bit overwrites the result last
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = PW'((int'(ptr) + k) % N);
    gnt = (|req) ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/rgb_mem_arb.sv
// rgb_mem_arb: round-robin SRAM port arbiter with burst lock and fixed-latency read return.
// Define RGB_MEM_ARB_STATS_EN to add the saturating stall_cnt output.
module rgb_mem_arb #(
  parameter int NREQ      = demosaic_pkg::NREQ,
  parameter int ADDR_W    = demosaic_pkg::ADDR_W,
  parameter int DATA_W    = demosaic_pkg::DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
`ifdef RGB_MEM_ARB_STATS_EN
  , output logic [15:0]            stall_cnt
`endif
);
  import demosaic_pkg::*;
  localparam int PW = $clog2(NREQ);
  arb_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, sel, pick_idx;
  logic [7:0] burst_q, burst_d;
  logic [NREQ-1:0] pick_gnt, own_oh, rd_tag_q, rd_tag_d, rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic mem_wr_q, mem_wr_d, acc, others;
  rr_pick #(.N(NREQ)) u_pick (.req(req), .ptr(ptr_q), .gnt(pick_gnt), .idx(pick_idx));
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    burst_d = burst_q;
    own_oh  = NREQ'(1) << owner_q;
    others  = |(req & ~own_oh);
    sel     = pick_idx;
    gnt     = '0;
    if (state_q == ARB) begin
      gnt = pick_gnt;
      if (|pick_gnt) begin
        ptr_d = PW'((int'(pick_idx) + 1) % NREQ);
        // a one-grant burst limit with someone waiting makes the lock pointless
        if (req_lock[pick_idx] && !(MAX_BURST <= 1 && |(req & ~pick_gnt))) begin
          state_d = LOCK;
          owner_d = pick_idx;
          burst_d = 8'd1;
        end
      end
    end else begin
      sel     = owner_q;
      gnt     = req[owner_q] ? own_oh : '0;
      burst_d = (burst_q >= 8'(MAX_BURST)) ? burst_q : burst_q + 8'd1;
      if (!req[owner_q] || !req_lock[owner_q] || (burst_d >= 8'(MAX_BURST) && others))
        state_d = ARB;
    end
    gnt         = reset ? '0 : gnt;
    acc         = |gnt;
    mem_wr_d    = acc & req_wr[sel];
    mem_addr_d  = acc ? req_addr[sel*ADDR_W +: ADDR_W] : mem_addr_q;
    mem_wdata_d = acc ? req_wdata[sel*DATA_W +: DATA_W] : mem_wdata_q;
    rd_tag_d    = (acc && !req_wr[sel]) ? gnt : '0;
    rd_valid_d  = rd_tag_q;
    rd_data_d   = (|rd_tag_q) ? mem_rdata : rd_data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_q     <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_tag_q    <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_tag_q    <= rd_tag_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
`ifdef RGB_MEM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (stall_q != 16'hFFFF && |(req & ~gnt)) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
endmodule
